serial_word_tx: RTL

- Host/test-side transmitter producing the bit-serial stream that feeds the self-test die's serial data input.
- Accepts 32-bit words over a valid/ready handshake and buffers them in a small FIFO.
- Emits each word as four bytes, 1 bit per t_clk, aligned to 8-cycle byte slots, so the die's deserializer and 8-to-32 packer see whole words.
- Also exports byte-slot phase and word-start markers so a bench or link partner can check alignment.

---
 rtl/serial_word_tx_pkg.sv | 14 +
 rtl/sync_word_fifo.sv | 64 ++++++
 rtl/serial_word_tx.sv | 106 ++++++++++
 3 files changed

// File: rtl/serial_word_tx_pkg.sv
// Shared word/byte geometry and transmitter state encoding for the serial
// word path (transmitter, 8-to-32 packer, 32-to-8 splitter).
package serial_word_tx_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = WORD_W / BYTE_W;

  typedef enum logic {
    IDLE,
    SEND
  } tx_state_t;

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock word FIFO with registered ready; occupancy counter drives
// full/empty so readers never see a word on the edge it was written.
module sync_word_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic             ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             push_en;
  logic             pop_en;

  assign push_en  = push & ready;
  assign pop_en   = pop & ~empty;
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({push_en, pop_en})
      2'b10:   count_next = count + ONE_CNT;
      2'b01:   count_next = count - ONE_CNT;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b1;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + ONE_PTR;
      if (pop_en)  rd_ptr <= rd_ptr + ONE_PTR;
      count <= count_next;
      ready <= (count_next != FULL_CNT);
    end
  end

endmodule

// File: rtl/serial_word_tx.sv
// Bit-serial word transmitter: buffers 32-bit words and shifts them out
// MSB first, each word starting on a byte-slot boundary (bit_phase 0).
module serial_word_tx
  import serial_word_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic        IDLE_BIT   = 1'b0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              t_clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              data_out,
  output logic [2:0]        bit_phase,
  output logic              word_start,
  output logic              busy,
  output logic [CNT_W-1:0]  words_sent
);

  localparam logic [2:0] LAST_PHASE = 3'(BYTE_W - 1);
  localparam logic [4:0] LAST_BIT   = 5'(WORD_W - 1);

  tx_state_t         state;
  tx_state_t         state_next;
  logic [WORD_W-1:0] shreg;
  logic [4:0]        bit_cnt;
  logic              pop;
  logic              word_done;
  logic [WORD_W-1:0] fifo_data;
  logic              fifo_full;
  logic              fifo_empty;

  sync_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (t_clk),
    .rst       (rst),
    .push_data (in_data),
    .push      (in_valid & ~fifo_full),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .ready     (in_ready)
  );

  assign busy = (state == SEND) | ~fifo_empty;

  // Loads happen only on the phase-7 edge; bit 31 always lands there too,
  // so back-to-back words stay byte-aligned without an idle bit.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    word_done  = 1'b0;
    if (bit_phase == LAST_PHASE) begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = SEND;
          end
        end
        SEND: begin
          if (bit_cnt == LAST_BIT) begin
            word_done = 1'b1;
            if (!fifo_empty) pop = 1'b1;
            else             state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge t_clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_phase  <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      data_out   <= IDLE_BIT;
      word_start <= 1'b0;
      words_sent <= '0;
    end else begin
      bit_phase  <= bit_phase + 3'd1;
      state      <= state_next;
      word_start <= pop;
      if (pop) begin
        data_out <= fifo_data[WORD_W-1];
        shreg    <= {fifo_data[WORD_W-2:0], 1'b0};
        bit_cnt  <= '0;
      end else if (state_next == SEND) begin
        data_out <= shreg[WORD_W-1];
        shreg    <= {shreg[WORD_W-2:0], 1'b0};
        bit_cnt  <= bit_cnt + 5'd1;
      end else begin
        data_out <= IDLE_BIT;
      end
      if (word_done) words_sent <= words_sent + CNT_W'(1);
    end
  end

endmodule
